// File: rtl/csum_pkg.sv
// Shared types and helpers for the ones-complement checksum datapath.
// Holds the checksum width, FSM encoding and end-around-carry fold.
package csum_pkg;

    localparam int CSUM_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } csum_state_e;

    // Two folds always clear the carry for any sum of up to 2^CSUM_W words.
    function automatic logic [CSUM_W-1:0] csum_fold(
        input logic [2*CSUM_W-1:0] x
    );
        logic [2*CSUM_W-1:0] t;
        t = {{CSUM_W{1'b0}}, x[CSUM_W-1:0]}
          + {{CSUM_W{1'b0}}, x[2*CSUM_W-1:CSUM_W]};
        t = {{CSUM_W{1'b0}}, t[CSUM_W-1:0]}
          + {{CSUM_W{1'b0}}, t[2*CSUM_W-1:CSUM_W]};
        return t[CSUM_W-1:0];
    endfunction

endpackage

// File: rtl/csum_beat_add.sv
// Combinational beat adder: byte masking, N-word add with acc, fold.
// Shared between the TX generate and RX verify checksum paths.
module csum_beat_add
    import csum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SUM_W  = CSUM_W,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic [SUM_W-1:0]  acc_i,
    output logic [SUM_W-1:0]  sum_o
);

    localparam int N = DATA_W / SUM_W;

    logic [DATA_W-1:0]  masked;
    logic [2*SUM_W-1:0] wide;

    always_comb begin
        masked = data_i;
        for (int b = 0; b < KEEP_W; b++) begin
            if (!keep_i[b]) begin
                masked[b*8 +: 8] = 8'h00;
            end
        end
        wide = {{SUM_W{1'b0}}, acc_i};
        for (int w = 0; w < N; w++) begin
            wide = wide + {{SUM_W{1'b0}}, masked[w*SUM_W +: SUM_W]};
        end
        sum_o = csum_fold(wide);
    end

endmodule

// File: rtl/checksum_acc.sv
// Streaming ones-complement checksum accumulator with seeded start,
// mid-frame restart and a one-cycle result pulse after the last beat.
module checksum_acc
    import csum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SUM_W  = CSUM_W,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              data_v_i,
    input  logic              data_start_i,
    input  logic              data_last_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] data_keep_i,
    input  logic [SUM_W-1:0]  seed_i,
    output logic              busy_o,
    output logic              csum_v_o,
    output logic [SUM_W-1:0]  csum_o
);

    csum_state_e      state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] csum_q, csum_d;
    logic             csum_v_q, csum_v_d;
    logic [SUM_W-1:0] acc_in;
    logic [SUM_W-1:0] beat_sum;

    assign acc_in = data_start_i ? seed_i : acc_q;

    csum_beat_add #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .KEEP_W (KEEP_W)
    ) u_beat_add (
        .data_i (data_i),
        .keep_i (data_keep_i),
        .acc_i  (acc_in),
        .sum_o  (beat_sum)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        csum_d   = csum_q;
        csum_v_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_v_i && data_start_i) begin
                    acc_d   = beat_sum;
                    state_d = data_last_i ? IDLE : ACC;
                end
            end
            ACC: begin
                // A start beat here abandons the open frame silently.
                if (data_v_i) begin
                    acc_d   = beat_sum;
                    state_d = data_last_i ? IDLE : ACC;
                end
            end
            default: state_d = IDLE;
        endcase
        if (data_v_i && data_last_i
            && (data_start_i || state_q == ACC)) begin
            csum_d   = ~beat_sum;
            csum_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            csum_q   <= '0;
            csum_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            csum_q   <= csum_d;
            csum_v_q <= csum_v_d;
        end
    end

    assign busy_o   = (state_q == ACC);
    assign csum_v_o = csum_v_q;
    assign csum_o   = csum_q;

endmodule
